fetch_sequencer: RTL

- Control sequencer for the 8-bit program counter and the program-memory read path.
- Each instruction: drives the PC onto the address bus, reads an opcode and an optional immediate byte, and increments the PC after each byte.
- Hands the instruction to the execute unit, then waits for completion.
- Applies jumps by pulsing the PC load with a latched target.
- Sits between the PC, program memory, instruction register and execute unit.

---
 rtl/edic_ctrl_pkg.sv | 23 ++
 rtl/fetch_sequencer_mem_wait_timer.sv | 28 ++
 rtl/fetch_sequencer.sv | 119 +++++++++++
 3 files changed

// File: rtl/edic_ctrl_pkg.sv
// Shared definitions for the instruction fetch sequencer: state encoding,
// parameter limits and the opcode decode helper for the immediate flag.
package edic_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        FETCH_OP  = 3'd1,
        FETCH_IMM = 3'd2,
        ISSUE     = 3'd3,
        JUMP      = 3'd4,
        HALTED    = 3'd5
    } fetch_state_t;

    localparam int unsigned IMM_BIT_DEFAULT = 7;
    localparam int unsigned MEM_WAIT_MAX    = 15;

    // True when the opcode announces one trailing immediate byte.
    function automatic logic opcode_has_imm(input logic [7:0] opcode,
                                            input int unsigned imm_bit);
        return opcode[imm_bit[2:0]];
    endfunction

endpackage

// File: rtl/fetch_sequencer_mem_wait_timer.sv
// Memory read timer shared by both fetch states. The count is reloaded to
// zero while 'load' is high and advances while 'enable' is high; 'done'
// flags the final cycle of a read, i.e. when the count reaches 'last'.
module mem_wait_timer (
    input  logic       clk,
    input  logic       reset,
    input  logic       load,
    input  logic       enable,
    input  logic [3:0] last,
    output logic       done
);

    logic [3:0] count;

    assign done = enable && (count == last);

    // Reload on entry to a read (and after its last cycle), otherwise count.
    always_ff @(posedge clk) begin
        if (reset) begin
            count <= 4'd0;
        end else if (load) begin
            count <= 4'd0;
        end else if (enable) begin
            count <= count + 4'd1;
        end
    end

endmodule

// File: rtl/fetch_sequencer.sv
// Fetch sequencer: steps the PC through program memory, collects an opcode
// and an optional immediate byte, hands the instruction to the execute unit
// and applies jumps or a halt once the execute unit reports completion.
module fetch_sequencer
    import edic_ctrl_pkg::*;
#(
    parameter int unsigned MEM_WAIT = 1,
    parameter int unsigned IMM_BIT  = IMM_BIT_DEFAULT
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_run,
    input  logic [7:0] i_memData,
    input  logic       i_execDone,
    input  logic       i_jumpTaken,
    input  logic [7:0] i_jumpTarget,
    input  logic       i_halt,
    output logic       o_pcOe,
    output logic       o_pcIncr,
    output logic       o_pcLoad,
    output logic [7:0] o_pcData,
    output logic       o_memRead,
    output logic       o_irLoad,
    output logic [7:0] o_opcode,
    output logic [7:0] o_imm,
    output logic       o_instrValid,
    output logic       o_halted
);

    // Index of the last cycle of a read; out-of-range settings are clamped.
    localparam logic [3:0] WAIT_LAST =
        (MEM_WAIT < 1)            ? 4'd0 :
        (MEM_WAIT > MEM_WAIT_MAX) ? 4'(MEM_WAIT_MAX - 1) :
                                    4'(MEM_WAIT - 1);

    fetch_state_t state;
    logic         in_fetch;
    logic         read_done;

    assign in_fetch = (state == FETCH_OP) || (state == FETCH_IMM);

    mem_wait_timer u_timer (
        .clk    (i_clk),
        .reset  (i_reset),
        .load   (!in_fetch || read_done),
        .enable (in_fetch),
        .last   (WAIT_LAST),
        .done   (read_done)
    );

    // Strobes are pure functions of the state and the read timer.
    assign o_pcOe       = in_fetch;
    assign o_memRead    = in_fetch;
    assign o_pcIncr     = in_fetch && read_done;
    assign o_pcLoad     = (state == JUMP);
    assign o_instrValid = (state == ISSUE);
    assign o_halted     = (state == HALTED);

    // State sequencing plus the opcode, immediate and jump target latches.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state    <= IDLE;
            o_opcode <= 8'h00;
            o_imm    <= 8'h00;
            o_pcData <= 8'h00;
            o_irLoad <= 1'b0;
        end else begin
            o_irLoad <= 1'b0;
            case (state)
                IDLE: begin
                    if (i_run) begin
                        state <= FETCH_OP;
                    end
                end
                FETCH_OP: begin
                    if (read_done) begin
                        o_opcode <= i_memData;
                        if (opcode_has_imm(i_memData, IMM_BIT)) begin
                            state <= FETCH_IMM;
                        end else begin
                            o_imm    <= 8'h00;
                            o_irLoad <= 1'b1;
                            state    <= ISSUE;
                        end
                    end
                end
                FETCH_IMM: begin
                    if (read_done) begin
                        o_imm    <= i_memData;
                        o_irLoad <= 1'b1;
                        state    <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (i_execDone) begin
                        if (i_jumpTaken) begin
                            o_pcData <= i_jumpTarget;
                            state    <= JUMP;
                        end else if (i_halt) begin
                            state <= HALTED;
                        end else begin
                            state <= i_run ? FETCH_OP : IDLE;
                        end
                    end
                end
                JUMP: begin
                    state <= i_run ? FETCH_OP : IDLE;
                end
                HALTED: begin
                    state <= HALTED;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
